// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, one-cycle valid / framing-error pulses.
// Define UART_RX_MAJORITY_EN to decide each bit by 2-of-3 majority around the sample point.
module uart_rx #(
    parameter int unsigned FPGA_FREQ = 27,
    parameter int unsigned UART_FREQ = 115200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int unsigned CLKS_PER_BIT = FPGA_FREQ * 1000000 / UART_FREQ;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CntW         = $clog2(CLKS_PER_BIT);

    localparam logic [CntW-1:0] BitLast = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q;
    logic [CntW-1:0] bit_cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shreg_q;
    logic            armed_q;
    logic            rx_meta_q;
    logic            rx_s_q;
    logic            sample;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Decisions move one clock later so the window straddles the nominal sample point.
    localparam logic [CntW-1:0] StartPt = CntW'(HALF_BIT);

    logic [1:0] hist_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rx_s_q};
        end
    end

    always_comb begin
        sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
    end
`else
    localparam logic [CntW-1:0] StartPt = CntW'(HALF_BIT - 1);

    always_comb begin
        sample = rx_s_q;
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            armed_q    <= 1'b0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    bit_cnt_q <= '0;
                    bit_idx_q <= '0;
                    // A line held low (break or bad stop) must go high before a new start counts.
                    if (rx_s_q) begin
                        armed_q <= 1'b1;
                    end else if (armed_q) begin
                        armed_q <= 1'b0;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (bit_cnt_q == StartPt) begin
                        bit_cnt_q <= '0;
                        state_q   <= sample ? StIdle : StData;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (bit_cnt_q == BitLast) begin
                        bit_cnt_q          <= '0;
                        shreg_q[bit_idx_q] <= sample;
                        bit_idx_q          <= bit_idx_q + 1'b1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= StStop;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (bit_cnt_q == BitLast) begin
                        bit_cnt_q <= '0;
                        state_q   <= StIdle;
                        if (sample) begin
                            data_out   <= shreg_q;
                            data_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        rx_busy = (state_q != StIdle);
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx; expected bytes and pulse counts come from a frame-level model.
module tb_uart_rx;

    localparam int CPB  = 27 * 1000000 / 115200;
    localparam int HALF = CPB / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
    localparam logic [7:0] SpikeExp = 8'h00;
`else
    localparam int MAJ = 0;
    localparam logic [7:0] SpikeExp = 8'h08;
`endif
    localparam int LAT = 2 + HALF + 9 * CPB + 1 + MAJ;

    logic       clock = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       rx_busy;

    int unsigned cyc = 0;
    int          dv_cyc = 0;
    int          ferr_cnt = 0;
    int          both_cnt = 0;
    int          ferr_exp = 0;
    int          vecs = 0;
    int          miss = 0;
    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];

    uart_rx dut (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .rx_busy    (rx_busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (data_valid) begin
            got_q.push_back(data_out);
            dv_cyc <= int'(cyc);
        end
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
        if (data_valid && frame_err) both_cnt <= both_cnt + 1;
    end

    initial begin
        #(900000 * 10);
        $display("FAIL watchdog: observed no finish, expected finish within 900000 clocks");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        assert (got === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int n);
        rx = b;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) send_bit(d[i], CPB);
        send_bit(stop, CPB);
    endtask

    task automatic drain(input string tag);
        check({tag, " count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check(tag, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int         start;
        logic [7:0] b;
        logic       stop;
        logic [7:0] part;

        rx    = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst data_out", data_out, 8'h00);
        check("rst data_valid", data_valid, 1'b0);
        check("rst frame_err", frame_err, 1'b0);
        check("rst rx_busy", rx_busy, 1'b0);

        reset = 1'b0;
        send_bit(1'b1, 1000);
        check("idle data_out", data_out, 8'h00);
        check("idle rx_busy", rx_busy, 1'b0);
        check("idle ferr", ferr_cnt, ferr_exp);
        drain("idle");

        start = int'(cyc);
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        send_bit(1'b1, CPB);
        check("a5 latency window", ((dv_cyc - start) >= 2224) && ((dv_cyc - start) <= 2231), 1'b1);
        check("a5 latency formula", dv_cyc - start, LAT);
        drain("a5");
        check("a5 ferr", ferr_cnt, ferr_exp);
        check("a5 data_out held", data_out, 8'hA5);

        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_bit(1'b1, CPB);
        drain("b2b");

        send_bit(1'b0, 10);
        check("glitch busy high", rx_busy, 1'b1);
        send_bit(1'b0, 40);
        send_bit(1'b1, 71);
        check("glitch busy cleared", rx_busy, 1'b0);
        send_bit(1'b1, CPB);
        drain("glitch");
        check("glitch ferr", ferr_cnt, ferr_exp);

        ferr_exp++;
        send_frame(8'h3C, 1'b0);
        send_bit(1'b0, 5 * CPB);
        check("break ferr", ferr_cnt, ferr_exp);
        check("break busy", rx_busy, 1'b0);
        check("break data_out held", data_out, 8'hFF);
        drain("break");
        send_bit(1'b1, CPB);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        send_bit(1'b1, CPB);
        drain("after break");
        check("after break data_out", data_out, 8'h55);
        check("after break ferr", ferr_cnt, ferr_exp);

        part = 8'h81;
        send_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) send_bit(part[i], CPB);
        send_bit(part[4], HALF);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("midreset data_out", data_out, 8'h00);
        check("midreset busy", rx_busy, 1'b0);
        reset = 1'b0;
        send_bit(1'b1, CPB);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        send_bit(1'b1, CPB);
        drain("midreset");
        check("midreset ferr", ferr_cnt, ferr_exp);

        for (int n = 0; n < 6; n++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_frame(b, stop);
            if (stop) begin
                exp_q.push_back(b);
            end else begin
                ferr_exp++;
                send_bit(1'b1, CPB);
            end
        end
        send_bit(1'b1, CPB);
        drain("random");
        check("random ferr", ferr_cnt, ferr_exp);

        // One-clock high spike captured at the centre of bit 3.
        send_bit(1'b0, CPB);
        for (int i = 0; i < 3; i++) send_bit(1'b0, CPB);
        send_bit(1'b0, HALF);
        send_bit(1'b1, 1);
        send_bit(1'b0, CPB - HALF - 1);
        for (int i = 4; i < 8; i++) send_bit(1'b0, CPB);
        send_bit(1'b1, CPB);
        send_bit(1'b1, CPB);
        exp_q.push_back(SpikeExp);
        drain("spike");

        check("valid and err overlap", both_cnt, 0);
        check("final ferr", ferr_cnt, ferr_exp);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
